// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch and load/store requesters
// Build option: define ARB_RR_EN for round-robin arbitration; default is fixed data-over-fetch priority.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          RESET,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
            $error("mem_port_arbiter: MEM_LAT must be in 1..7");
        end
    endgenerate

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t     r_state;
    logic       r_owner;
    logic       r_store;
    logic [2:0] r_cnt;

    logic w_idle;
    logic w_pick_d;
    logic w_grant;
    logic w_resp;

`ifdef ARB_RR_EN
    logic r_pri;
    assign w_pick_d = d_req && (!if_req || r_pri);
`else
    assign w_pick_d = d_req;
`endif

    // Grants are combinational, so they must be gated while reset is held.
    assign w_idle  = (r_state == ST_IDLE) && !RESET;
    assign w_grant = w_idle && (if_req || d_req);
    assign w_resp  = (r_state == ST_BUSY) && (r_cnt == LAT) && !RESET;

    assign if_gnt    = w_grant && !w_pick_d;
    assign d_gnt     = w_grant && w_pick_d;
    assign mem_en    = w_grant;
    assign mem_we    = d_gnt && d_we;
    assign mem_addr  = d_gnt ? d_addr : (if_gnt ? if_addr : '0);
    assign mem_wdata = d_gnt ? d_wdata : '0;

    assign if_rvalid = w_resp && !r_owner;
    assign d_rvalid  = w_resp && r_owner;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    // A store acknowledge returns zero rather than whatever the memory drives.
    assign d_rdata   = (d_rvalid && !r_store) ? mem_rdata : '0;
    assign busy      = (r_state == ST_BUSY) && !RESET;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_store <= 1'b0;
            r_cnt   <= 3'd0;
`ifdef ARB_RR_EN
            r_pri   <= 1'b1;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_state <= ST_BUSY;
                        r_owner <= w_pick_d;
                        r_store <= w_pick_d && d_we;
                        r_cnt   <= 3'd1;
`ifdef ARB_RR_EN
                        r_pri   <= !w_pick_d;
`endif
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == LAT) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
